// File: rtl/knn_stream_packer.sv
// knn_stream_packer: packs a 32-bit word stream into multi-lane beats for the KNN core and times job completion.
`timescale 1ns/1ps
module knn_stream_packer #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5,
  parameter int numberOfChannels   = 2,
  parameter int doneDelay          = 10
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [15:0]                           num_points,
  input  logic [dataWidth-1:0]                  s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic                                  wr_en,
  output logic [numberOfChannels*dataWidth-1:0] dataValueIn,
  output logic                                  done,
  output logic                                  busy
);
  localparam int LW = numberOfChannels > 1 ? $clog2(numberOfChannels) : 1;
  localparam int DW = numberOfDimensions > 1 ? $clog2(numberOfDimensions) : 1;
  localparam int CW = $clog2(doneDelay + 2);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [DW-1:0] dim_q, dim_d;
  logic [15:0] point_q, point_d, np_q, np_d;
  logic [CW-1:0] drain_q, drain_d;
  logic [dataWidth-1:0] lanes_q [numberOfChannels];
  logic [dataWidth-1:0] lanes_d [numberOfChannels];
  logic [numberOfChannels*dataWidth-1:0] dout_q, dout_d;
  logic wr_en_q, wr_en_d, done_q, done_d;
  logic acc, lane_last, dim_last, last_word;
  always_comb begin
    acc = state_q == LOAD && s_valid;
    lane_last = lane_q == LW'(numberOfChannels - 1);
    dim_last = dim_q == DW'(numberOfDimensions - 1);
    last_word = acc && lane_last && dim_last && point_q == np_q;
    state_d = state_q;
    lane_d = lane_q;
    dim_d = dim_q;
    point_d = point_q;
    np_d = np_q;
    drain_d = drain_q;
    done_d = done_q;
    wr_en_d = acc && lane_last;
    dout_d = dout_q;
    for (int i = 0; i < numberOfChannels; i++) begin
      lanes_d[i] = (acc && lane_q == LW'(i)) ? s_data : lanes_q[i];
      dout_d[i*dataWidth +: dataWidth] = wr_en_d ? lanes_d[i] : dout_q[i*dataWidth +: dataWidth];
    end
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = LOAD;
      np_d = num_points;
      lane_d = '0;
      dim_d = '0;
      point_d = '0;
      done_d = 1'b0;
    end
    if (acc) begin
      lane_d = lane_last ? '0 : lane_q + 1'b1;
      dim_d = lane_last ? (dim_last ? '0 : dim_q + 1'b1) : dim_q;
      point_d = (lane_last && dim_last) ? point_q + 16'd1 : point_q;
    end
    // Final word leaves LOAD immediately, so s_ready is already low on the following cycle.
    if (last_word) begin
      state_d = DRAIN;
      drain_d = CW'(doneDelay);
    end
    if (state_q == DRAIN) begin
      drain_d = drain_q - 1'b1;
      state_d = drain_q <= CW'(1) ? DONE : DRAIN;
      done_d = drain_q <= CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q <= '0;
      dim_q <= '0;
      point_q <= '0;
      np_q <= '0;
      drain_q <= '0;
      lanes_q <= '{default: '0};
      dout_q <= '0;
      wr_en_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      dim_q <= dim_d;
      point_q <= point_d;
      np_q <= np_d;
      drain_q <= drain_d;
      lanes_q <= lanes_d;
      dout_q <= dout_d;
      wr_en_q <= wr_en_d;
      done_q <= done_d;
    end
  end
  assign s_ready = state_q == LOAD;
  assign busy = state_q == LOAD || state_q == DRAIN;
  assign wr_en = wr_en_q;
  assign dataValueIn = dout_q;
  assign done = done_q;
endmodule
